// File: rtl/counter.sv
// Edge-triggered event counter: counts rising edges of `increment`, with a
// synchronous active-high reset and a build-time choice of wrap or saturate.
module counter #(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_inc_q;
    logic             w_rise;
    logic             w_at_max;
    logic             w_hold_at_max;

    // Rise of the request against the previous-edge sample, and saturation guard.
    always_comb begin
        w_rise        = increment & ~r_inc_q;
        w_at_max      = &r_count;
        w_hold_at_max = w_at_max & ~WRAP;
    end

    // Sample the request on every edge (even during reset) so that a level
    // held high across reset release is never mistaken for a fresh rise.
    always_ff @(posedge clk) begin
        r_inc_q <= increment;
    end

    // Count register: reset wins over a rise; the add naturally wraps modulo 2^WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_rise && !w_hold_at_max) begin
            r_count <= r_count + One;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: two instances (wrap and saturate) share stimulus.
module tb_counter;

    logic       clk;
    logic       reset;
    logic       increment;
    logic [7:0] count_wrap;
    logic [7:0] count_sat;

    int n_cmp;
    int n_err;

    counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap (
        .clk       (clk),
        .reset     (reset),
        .increment (increment),
        .count     (count_wrap)
    );

    counter #(.WIDTH(8), .WRAP(1'b0)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .increment (increment),
        .count     (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic inc);
        @(negedge clk);
        reset     = rst;
        increment = inc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [7:0] exp);
        check({tag, "/wrap"}, count_wrap, exp);
        check({tag, "/sat"}, count_sat, exp);
    endtask

    initial begin
        logic [7:0] exp_wrap;
        logic [7:0] exp_sat;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        increment = 1'b0;

        // Reset for 5 edges
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check_both("reset", 8'd0);

        // Single pulse, visible right after the sampling edge, then idle
        step(1'b0, 1'b1);
        check_both("pulse1", 8'd1);
        step(1'b0, 1'b0);
        check_both("idle1", 8'd1);
        step(1'b0, 1'b0);
        check_both("idle2", 8'd1);

        // Two more pulses separated by one low cycle
        step(1'b0, 1'b1);
        check_both("pulse2", 8'd2);
        step(1'b0, 1'b0);
        check_both("gap", 8'd2);
        step(1'b0, 1'b1);
        check_both("pulse3", 8'd3);

        // Mid-operation reset, then resume from 0
        step(1'b1, 1'b0);
        check_both("midreset", 8'd0);
        step(1'b0, 1'b1);
        check_both("resume", 8'd1);
        step(1'b0, 1'b0);

        // Pulses while reset held are ignored
        step(1'b1, 1'b1);
        check_both("rstpulseA", 8'd0);
        step(1'b1, 1'b0);
        check_both("rstlowA", 8'd0);
        step(1'b1, 1'b1);
        check_both("rstpulseB", 8'd0);
        step(1'b1, 1'b0);
        check_both("rstlowB", 8'd0);
        step(1'b0, 1'b1);
        check_both("postrst1", 8'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_both("postrst2", 8'd2);
        step(1'b0, 1'b0);

        // Level held for 10 cycles yields exactly one increment
        step(1'b0, 1'b1);
        check_both("hold_first", 8'd3);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1);
            check_both("hold", 8'd3);
        end
        step(1'b0, 1'b0);
        check_both("hold_end", 8'd3);

        // Level held high across reset release never counts
        step(1'b1, 1'b1);
        check_both("acrossA", 8'd0);
        step(1'b1, 1'b1);
        check_both("acrossB", 8'd0);
        step(1'b0, 1'b1);
        check_both("acrossC", 8'd0);
        step(1'b0, 1'b1);
        check_both("acrossD", 8'd0);
        step(1'b0, 1'b0);
        check_both("acrossE", 8'd0);

        // 257 pulses from 0: wrap instance rolls 255->0->1, saturate instance sticks at 255
        for (int i = 1; i <= 257; i++) begin
            step(1'b0, 1'b1);
            exp_wrap = 8'(i % 256);
            exp_sat  = (i > 255) ? 8'd255 : 8'(i);
            check("sweep/wrap", count_wrap, exp_wrap);
            check("sweep/sat", count_sat, exp_sat);
            step(1'b0, 1'b0);
        end

        // Reset from a large value clears at the next edge
        step(1'b1, 1'b0);
        check_both("final_reset", 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8: width of the count register and of the count output.
REQ-002 Parameter WRAP, default 1: 1 = wrap from the maximum value to 0; 0 = saturate at the maximum value.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-005 Port increment, input, 1 bit: count request; each 0->1 transition requests exactly one increment.
REQ-006 Port count, output, WIDTH bits (8 at default): current counter value, driven directly from a register.

Function
REQ-007 The block SHALL hold two registers: count_r (WIDTH bits) and inc_q (1 bit, increment as sampled on the previous clk edge).
REQ-008 inc_q SHALL load increment on every rising clk edge, including edges where reset=1, so that a level held through reset release never generates a count.
REQ-009 The block SHALL detect a rise as increment=1 AND inc_q=0 at a clk edge.
REQ-010 On a clk edge with reset=0 and a detected rise, the block SHALL set count_r to count_r+1, computed modulo 2^WIDTH.
REQ-011 Latency: count SHALL show the new value immediately after the clk edge at which increment is first sampled high.
REQ-012 Holding increment high for N>1 cycles SHALL produce exactly one increment.
REQ-013 Holding increment low SHALL keep count unchanged.
REQ-014 With WRAP=1, a rise at count=2^WIDTH-1 (255 at default) SHALL produce count=0.
REQ-015 With WRAP=0, a rise at count=2^WIDTH-1 SHALL leave count at 2^WIDTH-1.
REQ-016 count SHALL have no combinational path from any input.
REQ-017 count SHALL change only on rising clk edges.

Reset
REQ-018 On a clk edge with reset=1, the block SHALL set count_r to 0; reset SHALL take priority over any rise.
REQ-019 While reset stays 1, count SHALL remain 0 regardless of increment activity.
REQ-020 Asserting reset mid-operation (any count value) SHALL clear count to 0 at the next clk edge.
REQ-021 Counting SHALL resume from 0 at the first rise detected on an edge with reset=0.
REQ-022 Before the first clk edge, count is undefined; verification SHALL apply reset for at least one edge before checking values.

Verification
REQ-023 Scenario: reset=1 for 5 edges, then reset=0; apply one 1-cycle increment pulse -> count=1 after the sampling edge; idle 2 cycles -> count stays 1.
REQ-024 Scenario: two further 1-cycle pulses separated by one low cycle -> count=2, then count=3.
REQ-025 Scenario: at count=3, assert reset=1 for 1 edge -> count=0; release reset and apply one pulse -> count=1.
REQ-026 Scenario: hold reset=1 while applying two 1-cycle pulses -> count stays 0 throughout; release reset and apply two pulses -> count=1, then count=2.
REQ-027 Scenario: hold increment high for 10 cycles -> count rises by exactly 1; holding increment high across reset release -> count stays 0.
REQ-028 Scenario: apply 256 pulses from count=0 with WRAP=1 -> count wraps 255->0; repeat with WRAP=0 -> count holds at 255.
